// File: rtl/dance_round_ctrl.sv
// dance_round_ctrl: round scheduler for Finger-Dancer (pattern pick, response timing, BCD score, lives)
module dance_round_ctrl #(
   parameter int WINDOW_CYC = 25000000,
   parameter int GAP_CYC    = 12500000,
   parameter int LIVES      = 3
) (
   input  logic       clk,
   input  logic       res,
   input  logic       start,
   input  logic [3:0] btn,
   output logic [3:0] pattern,
   output logic [7:0] score,
   output logic       C,
   output logic [1:0] lives,
   output logic       game_over
);
   localparam int TW = $clog2(WINDOW_CYC > GAP_CYC ? WINDOW_CYC : GAP_CYC) + 1;
   localparam logic [1:0] LIVES_INIT = 2'(LIVES);
   localparam logic [TW-1:0] WIN_LOAD = TW'(WINDOW_CYC - 1);
   localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYC - 1);
   typedef enum logic [2:0] {IDLE, SHOW, WAIT, GAP, OVER} state_t;
   state_t        state_q;
   logic [3:0]    btn_s1_q, btn_s2_q, btn_e_q;
   logic          start_s1_q, start_s2_q, start_e_q;
   logic [7:0]    lfsr_q, lfsr_d;
   logic [3:0]    prev_q, one, cand;
   logic [TW-1:0] timer_q;
   logic [7:0]    score_inc;
   logic          press, start_rise, hit, last_life;
   always_comb begin
      lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      one        = 4'b0001 << lfsr_q[1:0];
      cand       = (one == prev_q) ? {one[2:0], one[3]} : one;
      press      = |(btn_s2_q & ~btn_e_q);
      start_rise = start_s2_q & ~start_e_q;
      hit        = press && (btn_s2_q == pattern);
      last_life  = lives == 2'd1;
      score_inc  = (score == 8'h99) ? score :
                   (score[3:0] == 4'd9) ? {score[7:4] + 4'd1, 4'd0} :
                   {score[7:4], score[3:0] + 4'd1};
   end
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q    <= IDLE;
         btn_s1_q   <= '0;
         btn_s2_q   <= '0;
         btn_e_q    <= '0;
         start_s1_q <= 1'b0;
         start_s2_q <= 1'b0;
         start_e_q  <= 1'b0;
         lfsr_q     <= 8'h01;
         prev_q     <= '0;
         timer_q    <= '0;
         pattern    <= '0;
         score      <= 8'h00;
         C          <= 1'b0;
         lives      <= LIVES_INIT;
         game_over  <= 1'b0;
      end else begin
         btn_s1_q   <= btn;
         btn_s2_q   <= btn_s1_q;
         btn_e_q    <= btn_s2_q;
         start_s1_q <= start;
         start_s2_q <= start_s1_q;
         start_e_q  <= start_s2_q;
         lfsr_q     <= lfsr_d;
         C          <= 1'b0;
         case (state_q)
            IDLE, OVER: if (start_rise) begin
               score     <= 8'h00;
               lives     <= LIVES_INIT;
               game_over <= 1'b0;
               state_q   <= SHOW;
            end
            SHOW: begin
               pattern <= cand;
               prev_q  <= cand;
               C       <= 1'b1;
               timer_q <= WIN_LOAD;
               state_q <= WAIT;
            end
            // a press on the final window cycle wins over the timeout
            WAIT: if (press || timer_q == '0) begin
               C       <= 1'b1;
               timer_q <= GAP_LOAD;
               if (hit) begin
                  score   <= score_inc;
                  pattern <= 4'h0;
                  state_q <= GAP;
               end else begin
                  lives     <= lives - 2'd1;
                  pattern   <= last_life ? 4'hF : 4'h0;
                  game_over <= last_life;
                  state_q   <= last_life ? OVER : GAP;
               end
            end else begin
               timer_q <= timer_q - 1'b1;
            end
            GAP: if (timer_q == '0) state_q <= SHOW;
                 else timer_q <= timer_q - 1'b1;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dance_round_ctrl.sv
// tb_dance_round_ctrl: table-driven rounds plus directed start, BCD, and async-reset sequences
module tb_dance_round_ctrl;
   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic       start = 1'b0;
   logic [3:0] btn = 4'h0;
   logic [3:0] pattern;
   logic [7:0] score;
   logic       C;
   logic [1:0] lives;
   logic       game_over;
   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] m_q, mp_q;
   logic [3:0] pexp = 4'h0;

   typedef struct {
      int         kind;
      int         d;
      logic [7:0] sc;
      logic [1:0] lv;
      int         n;
      logic       ov;
   } vec_t;

   dance_round_ctrl #(.WINDOW_CYC(20), .GAP_CYC(4), .LIVES(3)) dut (
      .clk(clk), .res(res), .start(start), .btn(btn), .pattern(pattern),
      .score(score), .C(C), .lives(lives), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // reference LFSR (taps 8,6,5,4); mp_q holds the value seen at the previous edge
   always @(posedge clk or negedge res) begin
      if (!res) begin
         m_q  <= 8'h01;
         mp_q <= 8'h01;
      end else begin
         mp_q <= m_q;
         m_q  <= {m_q[6:0], m_q[7] ^ m_q[5] ^ m_q[4] ^ m_q[3]};
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_c(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!C && n < 100);
   endtask

   task automatic chk_show(input string nm);
      logic [3:0] c;
      c = 4'b0001 << mp_q[1:0];
      if (c == pexp) c = {c[2:0], c[3]};
      chk({nm, " onehot"}, 32'($onehot(pattern)), 1);
      chk({nm, " differs"}, 32'(pattern != pexp), 1);
      chk({nm, " pattern"}, pattern, c);
      pexp = c;
   endtask

   task automatic do_start(input string nm);
      int n;
      start = 1'b1;
      wait_c(n);
      chk({nm, " latency"}, n, 4);
      chk({nm, " score"}, score, 8'h00);
      chk({nm, " lives"}, lives, 3);
      chk({nm, " game_over"}, game_over, 0);
      chk_show(nm);
      start = 1'b0;
   endtask

   task automatic play(input vec_t v, input string nm);
      int n;
      logic [3:0] cp;
      cp = pattern;
      repeat (v.d) @(negedge clk);
      if (v.kind == 0) btn = cp;
      else if (v.kind == 1) btn = cp | {cp[2:0], cp[3]};
      wait_c(n);
      chk({nm, " round len"}, v.d + n, v.n);
      chk({nm, " score"}, score, v.sc);
      chk({nm, " lives"}, lives, v.lv);
      chk({nm, " end pattern"}, pattern, v.ov ? 4'hF : 4'h0);
      chk({nm, " game_over"}, game_over, v.ov);
      btn = 4'h0;
      if (!v.ov) begin
         wait_c(n);
         chk({nm, " gap len"}, n, 5);
         chk_show({nm, " next"});
      end
   endtask

   initial begin
      vec_t tv[9];
      int   cs, s;
      // kind: 0 hit, 1 multi-bit press, 2 no press; d = cycles into WAIT before pressing
      tv[0] = '{0,  5, 8'h01, 2'd3,  8, 1'b0};
      tv[1] = '{1,  5, 8'h01, 2'd2,  8, 1'b0};
      tv[2] = '{0, 17, 8'h02, 2'd2, 20, 1'b0};
      tv[3] = '{0, 18, 8'h02, 2'd1, 20, 1'b0};
      tv[4] = '{0,  0, 8'h03, 2'd1,  3, 1'b0};
      tv[5] = '{2,  0, 8'h03, 2'd0, 20, 1'b1};
      tv[6] = '{2,  0, 8'h00, 2'd2, 20, 1'b0};
      tv[7] = '{2,  0, 8'h00, 2'd1, 20, 1'b0};
      tv[8] = '{2,  0, 8'h00, 2'd0, 20, 1'b1};
      repeat (2) @(negedge clk);
      chk("reset pattern", pattern, 4'h0);
      chk("reset score", score, 8'h00);
      chk("reset C", C, 0);
      chk("reset lives", lives, 3);
      chk("reset game_over", game_over, 0);
      res = 1'b1;
      btn = 4'h1;
      cs = 0;
      repeat (6) begin
         @(negedge clk);
         cs += int'(C);
      end
      btn = 4'h0;
      chk("idle quiet C", cs, 0);
      chk("idle pattern", pattern, 4'h0);
      do_start("start0");
      for (int i = 0; i < 9; i++) begin
         if (i > 0 && tv[i-1].ov) begin
            btn = 4'hF;
            cs = 0;
            repeat (6) begin
               @(negedge clk);
               cs += int'(C);
            end
            btn = 4'h0;
            chk("over quiet C", cs, 0);
            chk("over pattern", pattern, 4'hF);
            chk("over game_over", game_over, 1);
            repeat (3) @(negedge clk);
            do_start($sformatf("restart%0d", i));
         end
         play(tv[i], $sformatf("v%0d", i));
      end
      repeat (3) @(negedge clk);
      do_start("bcd start");
      for (int k = 1; k <= 100; k++) begin
         vec_t hv;
         s = (k > 99) ? 99 : k;
         hv = '{0, 0, {4'(s / 10), 4'(s % 10)}, 2'd3, 3, 1'b0};
         play(hv, $sformatf("bcd%0d", k));
      end
      repeat (5) @(negedge clk);
      #2 res = 1'b0;
      #1;
      chk("async pattern", pattern, 4'h0);
      chk("async score", score, 8'h00);
      chk("async C", C, 0);
      chk("async lives", lives, 3);
      chk("async game_over", game_over, 0);
      @(negedge clk);
      res = 1'b1;
      pexp = 4'h0;
      repeat (3) @(negedge clk);
      chk("post reset idle", pattern, 4'h0);
      do_start("post reset start");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dance_round_ctrl.md
Name: dance_round_ctrl

Overview:
- Round scheduler for the Finger-Dancer game; sits between the debounced buttons and the `display` block.
- Picks a one-hot target pattern each round, times the player's response window, and judges the press.
- Keeps a 2-digit BCD score and a lives count.
- Drives `score`, `pattern` and the `C` load strobe consumed by `display`.

Parameters:
- WINDOW_CYC, 25000000, response window length in clk cycles (≥2).
- GAP_CYC, 12500000, blank interval between rounds in clk cycles (≥1).
- LIVES, 3, misses allowed before game over (1..3).

Ports:
- clk  in  1  system clock.
- res  in  1  asynchronous active-low reset.
- start  in  1  debounced start button, level.
- btn  in  4  debounced finger buttons, level, asynchronous to clk.
- pattern  out  4  target LEDs to `display`.
- score  out  8  BCD score: [7:4] tens, [3:0] units.
- C  out  1  one-cycle strobe; `display` latches `score` and `pattern` on it.
- lives  out  2  remaining lives.
- game_over  out  1  high in OVER state.

Behaviour:
- Reset (res=0, asynchronous):
  - state=IDLE; pattern=0, score=8'h00, C=0, lives=LIVES, game_over=0.
  - LFSR=8'h01; all timers=0; sync flops=0.
- Input conditioning:
  - btn passes through a 2-flop synchronizer, then an edge register.
  - press = rising edge of any synchronized bit.
  - A press is judged on the 3rd rising clk edge after btn changes.
  - start is conditioned identically (start_rise).
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4, free-running every cycle from reset.
  - Candidate pattern = 1 << lfsr[1:0].
  - If the candidate equals the previous round's pattern, rotate it left by 1.
- States and transitions:
  - IDLE: pattern=0. On start_rise: score=0, lives=LIVES, go to SHOW.
  - SHOW (1 cycle): load pattern from LFSR, C=1, timer=WINDOW_CYC-1, go to WAIT.
  - WAIT: timer decrements each cycle.
    - Press with synchronized btn == pattern exactly: hit. score+1 in BCD (09→10, 99 saturates at 99), go to GAP.
    - Press with any other value (including multi-bit): miss. lives-1, go to GAP.
    - timer==0 with no press: miss (timeout), go to GAP.
    - Press on the same cycle as timer==0: the press is judged; the timeout is ignored.
  - GAP: on entry pattern=0, C=1 (the C pulse carries the updated score). timer=GAP_CYC-1.
    - If lives==0 after the miss: go to OVER instead.
    - When timer==0: go to SHOW.
  - OVER: pattern=4'hF, game_over=1, C pulses once on entry. On start_rise: behaves as IDLE start (score=0, lives=LIVES, go to SHOW).
- Ignored inputs:
  - Presses in IDLE, SHOW, GAP and OVER are ignored; they do not queue.
  - start_rise in SHOW, WAIT and GAP is ignored.
- C rules:
  - Exactly one cycle high per SHOW entry, GAP entry and OVER entry; otherwise 0.
  - score and pattern are stable while C=1 and do not change except on C cycles.
  - Exception: the IDLE/OVER→SHOW start clears score one cycle before SHOW's C.
- Reset mid-operation returns to the reset values immediately; no partial round completes.

Test Plan (WINDOW_CYC=20, GAP_CYC=4, LIVES=3):
- Reset then release, start pulse:
  - pattern=0 and score=8'h00 during reset.
  - Within 4 clk of start: one C pulse, pattern one-hot, lives=3.
- Hit:
  - Drive btn=pattern 5 cycles into WAIT: C pulse, score=8'h01, pattern=0.
  - After 4 GAP cycles a new one-hot pattern appears that differs from the previous one.
- BCD carry and saturation:
  - Win 10 rounds: score=8'h10.
  - Force a 99 state then hit: score stays 8'h99.
- Wrong and multi-bit press:
  - btn=4'b0011 against pattern 4'b0001: lives 3→2, score unchanged, C pulse.
- Timeout and game over:
  - No presses for 3 rounds: each round ends exactly 20 cycles after SHOW with lives decremented.
  - After the 3rd: pattern=4'hF, game_over=1.
  - start_rise then restarts with score=0, lives=3.
- Edge cases:
  - Press landing on the timer==0 cycle: judged as a hit, not a timeout.
  - res asserted in mid-WAIT: all outputs return to reset values asynchronously, before the next clk edge.
